// File: rtl/note_envelope_driver_pkg.sv
// Shared constants and FSM encoding for the note envelope driver.
package note_envelope_driver_pkg;
    localparam int NOTE_W        = 6;
    localparam int DUR_W         = 6;
    localparam int GAP_W         = 3;
    localparam int BEATS_PER_SEC = 48;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;
endpackage

// File: rtl/note_envelope_driver_if.sv
// Note handshake, timing strobes and synthesizer-facing outputs of the driver.
interface note_envelope_driver_if;
    import note_envelope_driver_pkg::*;

    logic              play;
    logic              beat;
    logic              sample_tick;
    // A note transfers on any cycle where note_valid & note_ready are both high;
    // note_ready never looks at note_valid, and an offer outside IDLE is ignored.
    logic              note_valid;
    logic [NOTE_W-1:0] note_in;
    logic [DUR_W-1:0]  duration_in;
    logic              note_ready;
    logic [NOTE_W-1:0] note_out;
    logic [DUR_W-1:0]  note_duration;
    logic              generate_next_sample;
    logic              done_with_note;
    logic              busy;

    modport master (
        output play, beat, sample_tick, note_valid, note_in, duration_in,
        input  note_ready, note_out, note_duration, generate_next_sample,
               done_with_note, busy
    );

    modport slave (
        input  play, beat, sample_tick, note_valid, note_in, duration_in,
        output note_ready, note_out, note_duration, generate_next_sample,
               done_with_note, busy
    );
endinterface

// File: rtl/note_envelope_driver_beat_down_counter.sv
// Loadable down counter that stops at zero; load wins over decrement.
module beat_down_counter #(
    parameter int W = 6
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic [W-1:0] o_count,
    output logic         o_zero,
    output logic         o_one
);
    logic [W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_count = r_count;
    assign o_zero  = (r_count == '0);
    assign o_one   = (r_count == W'(1));
endmodule

// File: rtl/note_envelope_driver.sv
// Holds one note for its beat count, then an optional silent gap, gating codec
// sample requests while a note or gap is active.
module note_envelope_driver
    import note_envelope_driver_pkg::*;
#(
    parameter int GAP_BEATS = 1
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    note_envelope_driver_if.slave   bus,
    output state_t                  o_state
);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_BEATS);
    localparam bit               HAS_GAP  = (GAP_BEATS > 0);

    state_t             r_state;
    state_t             w_next;
    logic [NOTE_W-1:0]  r_note;
    logic [DUR_W-1:0]   r_dur;
    logic               r_done;

    logic               w_accept;
    logic               w_note_end;
    logic               w_gap_end;
    logic               w_note_zero, w_note_one;
    logic               w_gap_zero, w_gap_one;
    logic [DUR_W-1:0]   w_note_count;
    logic [GAP_W-1:0]   w_gap_count;

    assign w_accept   = (r_state == ST_IDLE) && bus.play && bus.note_valid;
    // A zero-length note ends on its first PLAY cycle without waiting for a beat.
    assign w_note_end = (r_state == ST_PLAY) && bus.play &&
                        (w_note_zero || (bus.beat && w_note_one));
    assign w_gap_end  = (r_state == ST_GAP) && bus.play &&
                        (w_gap_zero || (bus.beat && w_gap_one));

    beat_down_counter #(.W(DUR_W)) u_note_cnt (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_load     (w_accept),
        .i_load_val (bus.duration_in),
        .i_dec      ((r_state == ST_PLAY) && bus.play && bus.beat),
        .o_count    (w_note_count),
        .o_zero     (w_note_zero),
        .o_one      (w_note_one)
    );

    beat_down_counter #(.W(GAP_W)) u_gap_cnt (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_load     (w_note_end && HAS_GAP),
        .i_load_val (GAP_LOAD),
        .i_dec      ((r_state == ST_GAP) && bus.play && bus.beat),
        .o_count    (w_gap_count),
        .o_zero     (w_gap_zero),
        .o_one      (w_gap_one)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_note  <= '0;
            r_dur   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= w_accept;
            if (w_accept) begin
                r_note <= bus.note_in;
                r_dur  <= bus.duration_in;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)   w_next = ST_PLAY;
            ST_PLAY: if (w_note_end) w_next = HAS_GAP ? ST_GAP : ST_IDLE;
            ST_GAP:  if (w_gap_end)  w_next = ST_IDLE;
            default:                 w_next = ST_IDLE;
        endcase
    end

    assign bus.note_ready           = (r_state == ST_IDLE) && bus.play;
    assign bus.note_out             = (r_state == ST_PLAY) ? r_note : '0;
    assign bus.note_duration        = r_dur;
    assign bus.generate_next_sample = bus.sample_tick && bus.play && (r_state != ST_IDLE);
    assign bus.done_with_note       = r_done;
    assign bus.busy                 = (r_state != ST_IDLE);
    assign o_state                  = r_state;
endmodule

// File: tb/tb_note_envelope_driver.sv
// Drives a GAP_BEATS=1 and a GAP_BEATS=0 driver with identical stimulus and
// compares every output each cycle against a beat-counting reference model.
module tb_note_envelope_driver;
    import note_envelope_driver_pkg::*;

    logic   clk = 1'b0;
    logic   reset;
    state_t st_a, st_b;
    int     checks = 0;
    int     errors = 0;

    always #5 clk = ~clk;

    note_envelope_driver_if if_a();
    note_envelope_driver_if if_b();

    note_envelope_driver #(.GAP_BEATS(1)) dut_a (
        .i_clk(clk), .i_reset(reset), .bus(if_a), .o_state(st_a));
    note_envelope_driver #(.GAP_BEATS(0)) dut_b (
        .i_clk(clk), .i_reset(reset), .bus(if_b), .o_state(st_b));

    // Reference model: phase 0 silent/idle, 1 sounding, 2 silent gap.
    int gap_cfg[2] = '{1, 0};
    int m_ph[2], m_left[2], m_note[2], m_dur[2], m_done[2];
    bit c_rst, c_play, c_beat, c_tick, c_valid;
    int c_note, c_dur;

    task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            if (c_rst) begin
                m_ph[k] = 0; m_left[k] = 0; m_note[k] = 0; m_dur[k] = 0; m_done[k] = 0;
            end else begin
                m_done[k] = 0;
                if (c_play) begin
                    if (m_ph[k] == 0) begin
                        if (c_valid) begin
                            m_ph[k] = 1; m_note[k] = c_note; m_dur[k] = c_dur;
                            m_left[k] = c_dur; m_done[k] = 1;
                        end
                    end else if (m_ph[k] == 1) begin
                        if (m_left[k] > 0 && c_beat) m_left[k]--;
                        else if (m_left[k] > 0) continue;
                        if (m_left[k] == 0) begin
                            m_ph[k]   = (gap_cfg[k] > 0) ? 2 : 0;
                            m_left[k] = gap_cfg[k];
                        end
                    end else begin
                        if (c_beat) m_left[k]--;
                        if (m_left[k] <= 0) begin m_ph[k] = 0; m_left[k] = 0; end
                    end
                end
            end
        end
    endtask

    task automatic check_one(string p, int k, logic rdy, logic [5:0] nout,
                             logic [5:0] ndur, logic gen, logic done, logic bsy, state_t st);
        state_t es;
        es = (m_ph[k] == 0) ? ST_IDLE : (m_ph[k] == 1) ? ST_PLAY : ST_GAP;
        chk({p, "_ready"}, {7'd0, rdy}, {7'd0, (m_ph[k] == 0) && c_play});
        chk({p, "_note_out"}, {2'd0, nout}, (m_ph[k] == 1) ? 8'(m_note[k]) : 8'd0);
        chk({p, "_note_dur"}, {2'd0, ndur}, 8'(m_dur[k]));
        chk({p, "_gen_sample"}, {7'd0, gen}, {7'd0, c_tick && c_play && (m_ph[k] != 0)});
        chk({p, "_done"}, {7'd0, done}, 8'(m_done[k]));
        chk({p, "_busy"}, {7'd0, bsy}, {7'd0, m_ph[k] != 0});
        chk({p, "_state"}, {6'd0, st}, {6'd0, es});
    endtask

    task automatic cycle(bit rst, bit p, bit b, bit t, bit v, int n, int d);
        c_rst = rst; c_play = p; c_beat = b; c_tick = t; c_valid = v;
        c_note = n & 63; c_dur = d & 63;
        reset = rst;
        if_a.play = p; if_a.beat = b; if_a.sample_tick = t; if_a.note_valid = v;
        if_a.note_in = 6'(n); if_a.duration_in = 6'(d);
        if_b.play = p; if_b.beat = b; if_b.sample_tick = t; if_b.note_valid = v;
        if_b.note_in = 6'(n); if_b.duration_in = 6'(d);
        #2;
        check_one("a", 0, if_a.note_ready, if_a.note_out, if_a.note_duration,
                  if_a.generate_next_sample, if_a.done_with_note, if_a.busy, st_a);
        check_one("b", 1, if_b.note_ready, if_b.note_out, if_b.note_duration,
                  if_b.generate_next_sample, if_b.done_with_note, if_b.busy, st_b);
        @(posedge clk);
        model_step();
        #1;
    endtask

    initial begin
        c_rst = 1; c_play = 1; c_beat = 0; c_tick = 0; c_valid = 0; c_note = 0; c_dur = 0;
        reset = 1'b1;
        if_a.play = 1; if_a.beat = 0; if_a.sample_tick = 0; if_a.note_valid = 0;
        if_a.note_in = 0; if_a.duration_in = 0;
        if_b.play = 1; if_b.beat = 0; if_b.sample_tick = 0; if_b.note_valid = 0;
        if_b.note_in = 0; if_b.duration_in = 0;
        @(posedge clk);
        model_step();
        #1;

        // Reset held three cycles with play high, then note 20 for 3 beats.
        cycle(1, 1, 0, 0, 1, 20, 3);
        cycle(1, 1, 1, 1, 1, 20, 3);
        cycle(0, 1, 0, 0, 1, 20, 3);
        for (int i = 0; i < 24; i++) cycle(0, 1, (i % 4) == 3, (i % 2) == 0, 0, 0, 0);

        // Zero-length note: one PLAY cycle, then gap (a) or idle (b).
        cycle(0, 1, 0, 1, 1, 5, 0);
        for (int i = 0; i < 8; i++) cycle(0, 1, i == 4, 1, 0, 0, 0);

        // Pause for 200 cycles mid-note with beats, ticks and offers arriving.
        cycle(0, 1, 0, 0, 1, 33, 6);
        for (int i = 0; i < 10; i++) cycle(0, 1, (i % 4) == 1, 0, 0, 0, 0);
        for (int i = 0; i < 200; i++)
            cycle(0, 0, (i % 5) == 0, (i % 3) == 0, $urandom_range(0, 1), $urandom, $urandom);
        for (int i = 0; i < 30; i++) cycle(0, 1, (i % 4) == 1, 1, 1, 9, 1);
        for (int i = 0; i < 6; i++) cycle(0, 1, 1, 0, 0, 0, 0);

        // Sample ticks every 8 cycles across a 2-beat note and the idle after.
        cycle(0, 1, 0, 0, 1, 12, 2);
        for (int i = 0; i < 80; i++) cycle(0, 1, (i % 20) == 19, (i % 8) == 0, 0, 0, 0);

        // Reset two beats into a 24-beat note.
        cycle(0, 1, 0, 0, 1, 40, 24);
        for (int i = 0; i < 8; i++) cycle(0, 1, (i % 4) == 0, 0, 0, 0, 0);
        cycle(1, 1, 1, 1, 1, 7, 7);
        for (int i = 0; i < 4; i++) cycle(0, 1, 0, 1, 0, 0, 0);

        // Beat coincident with acceptance is ignored.
        cycle(0, 1, 1, 0, 1, 17, 2);
        for (int i = 0; i < 12; i++) cycle(0, 1, (i % 3) == 2, 0, 0, 0, 0);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++)
            cycle($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0,
                  $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 1), $urandom_range(0, 63),
                  ($urandom_range(0, 9) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 7));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/note_envelope_driver.md
NOTE_ENVELOPE_DRIVER -- requirements
Module: note_envelope_driver

Interface
REQ-001 Parameter GAP_BEATS, default 1: silent beats inserted after each note (0 = legato, max 7).
REQ-002 clk  in  1  system clock; the block uses one clock; all logic on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 play  in  1  level; 1 = run, 0 = pause (state and counters frozen).
REQ-005 beat  in  1  one-cycle strobe, 48 per second (1/48 s duration unit).
REQ-006 sample_tick  in  1  one-cycle codec strobe requesting the next sample.
REQ-007 note_valid  in  1  upstream note offered.
REQ-008 note_in  in  6  note index; 0 = rest.
REQ-009 duration_in  in  6  note length in beats.
REQ-010 note_ready  out  1  note accepted this cycle when note_valid & note_ready.
REQ-011 note_out  out  6  held note for the synthesizer; 0 when silent.
REQ-012 note_duration  out  6  held duration driving the dynamics block decay rate.
REQ-013 generate_next_sample  out  1  gated sample request to the dynamics block.
REQ-014 done_with_note  out  1  one-cycle pulse; rearms the dynamics envelope to full scale.
REQ-015 busy  out  1  high in any state but IDLE.

Function
REQ-016 FSM states IDLE, PLAY, GAP; encoding from shared package.
REQ-017 note_ready = 1 only in IDLE with play = 1; combinational, no dependence on note_valid.
REQ-018 IDLE with accept: next cycle state = PLAY, note_out/note_duration = captured inputs, beat counter = duration_in, done_with_note = 1 for that single cycle.
REQ-019 PLAY: counter decrements by 1 on each beat while play = 1; when counter reaches 0 (on the beat taking it 1->0), next state = GAP if GAP_BEATS > 0, else IDLE.
REQ-020 duration_in = 0: PLAY lasts exactly one cycle, then GAP/IDLE, no beat consumed.
REQ-021 GAP: note_out = 0, note_duration held; gap counter loaded with GAP_BEATS on entry, decrements on beat; at 0 -> IDLE.
REQ-022 generate_next_sample = sample_tick & play & (state == PLAY or GAP); combinational, zero latency; 0 in IDLE.
REQ-023 play = 0: no state change, no counter change, note_ready = 0, generate_next_sample = 0, outputs held.
REQ-024 beat coincident with acceptance: beat ignored; counting starts on first beat after entering PLAY.
REQ-025 beat and sample_tick coincident: both honoured independently in the same cycle.
REQ-026 Counter arithmetic unsigned 6-bit (gap 3-bit); never decrements below 0; no wrap.
REQ-027 note_valid held high in PLAY/GAP: not accepted; inputs may change freely without effect.

Reset
REQ-028 reset dominates all inputs including play; takes effect at next edge, also mid-note.
REQ-029 Reset values: state IDLE, counters 0, note_out 0, note_duration 0, done_with_note 0, busy 0; note_ready, generate_next_sample follow REQ-017/022.
REQ-030 No done_with_note pulse generated by reset or the first cycle after it.

Structure
REQ-031 Shared package holds FSM state constants, NOTE_W = 6, DUR_W = 6, BEATS_PER_SEC = 48.
REQ-032 One sub-module natural: beat_down_counter (loadable, enable, zero flag), instanced for note and gap counters.

Verification
REQ-033 reset 3 cycles, play = 1, note_valid with note 20, dur 3 -> ready high in IDLE, note_out = 20 and done pulse 1 cycle after accept, PLAY for 3 beats, GAP 1 beat, busy 0 after.
REQ-034 dur 0, GAP_BEATS = 0 -> PLAY one cycle, back to IDLE next cycle, exactly one done pulse.
REQ-035 play dropped for 200 cycles mid-PLAY with beats and ticks arriving -> counter, note_out unchanged, generate_next_sample stays 0, resumes remaining beats after.
REQ-036 sample_tick every 8 cycles over 2-beat note -> generate_next_sample mirrors every tick in PLAY/GAP, none in IDLE.
REQ-037 reset asserted 2 beats into 24-beat note -> next cycle IDLE, note_out 0, note_duration 0, no done pulse.
REQ-038 beat coincident with acceptance of dur 2 -> PLAY ends on 2nd subsequent beat, not 1st.
